add_share_arbiter: RTL and testbench
====================================

ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req0_valid  input  1  SHALL indicate requester 0 presents operands.
REQ-005 req0_a, req0_b  input  WIDTH each  SHALL be requester 0 operands.
REQ-006 req0_ready  output  1  SHALL indicate requester 0 operands are accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready SHALL mirror REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  SHALL indicate a result is presented.
REQ-009 res_data  output  WIDTH  SHALL be the sum, modified per REQ-024.
REQ-010 res_carry  output  1  SHALL be the carry-out of the unmodified WIDTH-bit addition.
REQ-011 res_id  output  1  SHALL identify the requester owning the result (0 or 1).
REQ-012 res_ready  input  1  SHALL indicate the consumer takes the result this cycle.

Function
REQ-013 The block SHALL share one WIDTH-bit adder between two requesters under a two-state FSM: IDLE, RESP.
REQ-014 In IDLE: grant = the sole valid requester; if both valid, grant = requester named by round-robin pointer rr.
REQ-015 reqN_ready SHALL be combinational: high only in IDLE, only for the granted requester, only while its valid is high; never both high.
REQ-016 Handshake fires on valid && ready; at that edge: res_data/res_carry <= sum of granted operands, res_id <= grant, res_valid <= 1, state <= RESP, rr <= ~grant.
REQ-017 Latency SHALL be exactly 1 cycle from handshake edge to res_valid high.
REQ-018 In RESP both reqN_ready SHALL be 0; res_data, res_carry, res_id SHALL hold stable until res_ready.
REQ-019 RESP with res_ready=1 at an edge: res_valid <= 0, state <= IDLE; no new acceptance in that same cycle (max throughput 1 result / 2 cycles).
REQ-020 Unaccepted requests SHALL NOT be latched; a requester dropping valid before ready loses nothing and gains no priority.
REQ-021 With only one requester active, it SHALL be granted on every IDLE cycle regardless of rr.
REQ-022 Wrap-around: sum is (a+b) mod 2^WIDTH, carry = bit WIDTH of the full sum; e.g. 0xFF+0x01 -> 0x00, carry 1.
REQ-023 res_ready while res_valid=0 SHALL be ignored.

Configuration
REQ-024 Macro ADD_SHARE_ARBITER_SATURATE_EN: defined -> res_data SHALL clamp to all-ones when carry=1; undefined -> res_data SHALL be the wrapped sum; res_carry SHALL behave identically in both builds.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, rr=0, res_valid=0, res_data=0, res_carry=0, res_id=0, independent of clk.
REQ-026 While rst_n low, req0_ready and req1_ready SHALL be 0.
REQ-027 Reset asserted in RESP SHALL discard the pending result; first cycle after release SHALL grant per REQ-014 with rr=0.

Verification
REQ-028 Req0 only, a=0x12 b=0x34, res_ready=1 -> req0_ready same cycle, next cycle res_valid=1, res_data=0x46, carry 0, res_id 0, IDLE after.
REQ-029 Both valid continuously, res_ready=1 -> grants alternate 0,1,0,1 with res_id matching; each result 2 cycles apart.
REQ-030 Req1 a=0xFF b=0x01 -> res_data 0x00 carry 1 (macro undefined); res_data 0xFF carry 1 (macro defined).
REQ-031 Result held with res_ready=0 for 5 cycles while both requesters valid -> outputs stable, both ready 0; accept resumes only after res_ready.
REQ-032 rst_n pulsed low mid-RESP -> res_valid 0 without clock edge; after release, simultaneous requests grant requester 0 first.

Source files
------------

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one WIDTH-bit adder shared by two requesters.
// A two-state FSM (IDLE/RESP) grants one requester per transaction, using a
// round-robin pointer when both request, and presents the registered result
// until the consumer takes it.
//
// Build option: define ADD_SHARE_ARBITER_SATURATE_EN to clamp res_data to
// all-ones on carry-out; otherwise res_data is the wrapped sum.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid, reqN_a, reqN_b   requester N operands (N = 0, 1)
//   reqN_ready                   requester N accepted this cycle (combinational)
//   res_valid, res_data          registered result and its valid
//   res_carry, res_id            carry-out of the raw sum, owning requester
//   res_ready                    consumer takes the result this cycle
module add_share_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_id,
    input  logic             res_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             grant_c;
    logic             fire_c;
    logic [WIDTH-1:0] op_a_c, op_b_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] data_c;

    // Grant: sole valid requester wins; on contention the pointer decides.
    always_comb begin
        grant_c = rr_q;
        if (req0_valid && !req1_valid) begin
            grant_c = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_c = 1'b1;
        end
    end

    // Ready only in IDLE for the granted, valid requester; gated by reset.
    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant_c;
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant_c;
    assign fire_c     = req0_ready || req1_ready;

    // Shared adder on the granted operands.
    assign op_a_c = grant_c ? req1_a : req0_a;
    assign op_b_c = grant_c ? req1_b : req0_b;
    assign sum_c  = {1'b0, op_a_c} + {1'b0, op_b_c};

`ifdef ADD_SHARE_ARBITER_SATURATE_EN
    assign data_c = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
`else
    assign data_c = sum_c[WIDTH-1:0];
`endif

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state logic; the cycle that retires a result never accepts.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (fire_c) begin
                    state_d = RESP;
                    rr_d    = ~grant_c;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers: loaded on handshake, held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            res_valid <= (state_d == RESP);
            if (fire_c) begin
                res_data  <= data_c;
                res_carry <= sum_c[WIDTH];
                res_id    <= grant_c;
            end
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter with a result scoreboard.
module tb_add_share_arbiter;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             carry;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_id;
    logic             res_ready;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic m_rr   = 1'b0;
    logic m_resp = 1'b0;

    always #5 clk = ~clk;

    add_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_sum(input logic id, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        exp_t e;
        int   s;
        s       = int'(a) + int'(b);
        e.id    = id;
        e.carry = (s >= 256);
`ifdef ADD_SHARE_ARBITER_SATURATE_EN
        e.data  = e.carry ? 8'hFF : WIDTH'(s);
`else
        e.data  = WIDTH'(s);
`endif
        return e;
    endfunction

    // One cycle: check readies and result against the model, then advance
    // to the next falling edge, where the caller changes inputs.
    task automatic tick();
        logic g, e0, e1;
        #1;
        g  = m_rr;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!m_resp) begin
            if (req0_valid && !req1_valid) g = 1'b0;
            else if (req1_valid && !req0_valid) g = 1'b1;
            e0 = req0_valid && !g;
            e1 = req1_valid && g;
        end
        check(32'(req0_ready), 32'(e0), "req0_ready");
        check(32'(req1_ready), 32'(e1), "req1_ready");
        check(32'(res_valid), 32'(m_resp), "res_valid");
        if (m_resp) begin
            if (sb_q.size() == 0) begin
                check(32'(0), 32'(1), "scoreboard_empty");
            end else begin
                check(32'(res_id), 32'(sb_q[0].id), "res_id");
                check(32'(res_data), 32'(sb_q[0].data), "res_data");
                check(32'(res_carry), 32'(sb_q[0].carry), "res_carry");
                if (res_ready) begin
                    void'(sb_q.pop_front());
                    m_resp = 1'b0;
                end
            end
        end else if (e0 || e1) begin
            sb_q.push_back(g ? model_sum(1'b1, req1_a, req1_b)
                             : model_sum(1'b0, req0_a, req0_b));
            m_rr   = ~g;
            m_resp = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0;

        // Reset state, readies held low while in reset
        #3;
        check(32'(req0_ready), 32'(0), "rst_req0_ready");
        check(32'(req1_ready), 32'(0), "rst_req1_ready");
        check(32'(res_valid), 32'(0), "rst_res_valid");
        check(32'(res_data), 32'(0), "rst_res_data");
        check(32'(res_carry), 32'(0), "rst_res_carry");
        check(32'(res_id), 32'(0), "rst_res_id");
        @(negedge clk); @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // res_ready while idle is ignored
        res_ready = 1'b1;
        tick(); tick();

        // Requester 0 alone: 0x12 + 0x34
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        check(32'(req0_ready), 32'(1), "r0_only_ready");
        tick();
        req0_valid = 1'b0;
        #1;
        check(32'(res_valid), 32'(1), "r0_latency");
        check(32'(res_data), 32'(8'h46), "r0_sum");
        check(32'(res_carry), 32'(0), "r0_carry");
        check(32'(res_id), 32'(0), "r0_id");
        tick(); tick();

        // Both valid continuously: alternating grants, one result per 2 cycles
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
            req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();

        // Requester 1 wrap-around: 0xFF + 0x01
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
        tick();
        req1_valid = 1'b0;
        #1;
`ifdef ADD_SHARE_ARBITER_SATURATE_EN
        check(32'(res_data), 32'(8'hFF), "wrap_data");
`else
        check(32'(res_data), 32'(8'h00), "wrap_data");
`endif
        check(32'(res_carry), 32'(1), "wrap_carry");
        check(32'(res_id), 32'(1), "wrap_id");
        tick(); tick();

        // Result held 5 cycles with both requesters valid
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h7C;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
        tick();
        for (int i = 0; i < 5; i++) begin
            req0_a = WIDTH'($urandom); req1_a = WIDTH'($urandom);
            tick();
        end
        res_ready = 1'b1;
        tick(); tick(); tick(); tick();

        // Requester drops valid before being served; the other is granted alone
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        res_ready = 1'b1;
        tick(); tick();
        req1_valid = 1'b0;
        tick();

        // Reset mid-RESP discards the result without a clock edge
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        tick(); tick();
        #1;
        rst_n = 1'b0;
        #1;
        check(32'(res_valid), 32'(0), "midrst_res_valid");
        check(32'(res_data), 32'(0), "midrst_res_data");
        check(32'(req0_ready), 32'(0), "midrst_req0_ready");
        check(32'(req1_ready), 32'(0), "midrst_req1_ready");
        sb_q.delete();
        m_rr = 1'b0; m_resp = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; res_ready = 1'b1;
        req0_a = 8'h01; req0_b = 8'h02; req1_a = 8'h10; req1_b = 8'h20;
        #1;
        check(32'(req0_ready), 32'(1), "postrst_grant0");
        check(32'(req1_ready), 32'(0), "postrst_no_grant1");
        tick();
        #1;
        check(32'(res_id), 32'(0), "postrst_id");
        check(32'(res_data), 32'(8'h03), "postrst_data");
        tick(); tick(); tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
